// File: rtl/weight_column_loader_pkg.sv
// rtl/weight_column_loader_pkg.sv - shared state encoding and default widths for the weight column loader
package weight_column_loader_pkg;

  localparam int DEFAULT_ARRAY_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_INDEX_WIDTH = $clog2(DEFAULT_ARRAY_WIDTH);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/weight_column_loader_if.sv
// rtl/weight_column_loader_if.sv - upstream weight stream and top-PE column bus of the loader
interface weight_column_loader_if
  import weight_column_loader_pkg::*;
#(
  parameter int DATA_WIDTH_IN = DEFAULT_DATA_WIDTH,
  parameter int INDEX_WIDTH   = DEFAULT_INDEX_WIDTH
);
  logic                            load_valid_in;
  logic                            load_ready_out;
  logic signed [DATA_WIDTH_IN-1:0] load_weight_in;
  logic                            load_last_in;
  logic                            col_accept_w_out;
  logic [INDEX_WIDTH-1:0]          col_index_out;
  logic signed [DATA_WIDTH_IN-1:0] col_weight_out;

  modport master (
    output load_valid_in, load_weight_in, load_last_in,
    input  load_ready_out, col_accept_w_out, col_index_out, col_weight_out
  );

  modport slave (
    input  load_valid_in, load_weight_in, load_last_in,
    output load_ready_out, col_accept_w_out, col_index_out, col_weight_out
  );
endinterface

// File: rtl/weight_column_loader.sv
// rtl/weight_column_loader.sv - buffers one weight tile and streams it into a systolic column, deepest row first
module weight_column_loader
  import weight_column_loader_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = DEFAULT_ARRAY_WIDTH,
  parameter int DATA_WIDTH_IN        = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  weight_column_loader_if.slave bus,
  input  logic                  stream_go_in,
  input  logic                  err_clr_in,
  output logic                  busy_out,
  output logic                  tile_loaded_out,
  output logic                  tile_err_out
);
  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [IW-1:0] ROW_LAST = IW'(N - 1);

  loader_state_e                   state;
  logic [CW-1:0]                   cnt;
  logic signed [DATA_WIDTH_IN-1:0] wbuf [N];
  logic                            load_ready_q;
  logic                            accept_q;
  logic [IW-1:0]                   index_q;
  logic signed [DATA_WIDTH_IN-1:0] weight_q;
  logic                            xfer;
  logic [IW-1:0]                   wr_row;
  logic [IW-1:0]                   rd_row;

  assign xfer   = bus.load_valid_in && load_ready_q;
  assign wr_row = cnt[IW-1:0];
  assign rd_row = ROW_LAST - cnt[IW-1:0];

  assign bus.load_ready_out   = load_ready_q;
  assign bus.col_accept_w_out = accept_q;
  assign bus.col_index_out    = index_q;
  assign bus.col_weight_out   = weight_q;

  // Ready is only high in FILL, so a transfer can never overwrite a tile being streamed.
  always_ff @(posedge clk) begin
    if (xfer) wbuf[wr_row] <= bus.load_weight_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= FILL;
      cnt             <= '0;
      load_ready_q    <= 1'b0;
      accept_q        <= 1'b0;
      index_q         <= '0;
      weight_q        <= '0;
      busy_out        <= 1'b0;
      tile_loaded_out <= 1'b0;
      tile_err_out    <= 1'b0;
    end else begin
      accept_q        <= 1'b0;
      index_q         <= '0;
      weight_q        <= '0;
      tile_loaded_out <= 1'b0;
      if (err_clr_in) tile_err_out <= 1'b0;
      case (state)
        FILL: begin
          load_ready_q <= 1'b1;
          if (xfer) begin
            // The counter alone closes the tile; a misplaced last only flags an error.
            if (bus.load_last_in != (cnt == CNT_LAST)) tile_err_out <= 1'b1;
            if (cnt == CNT_LAST) begin
              state        <= READY;
              cnt          <= '0;
              load_ready_q <= 1'b0;
              busy_out     <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        READY: begin
          if (stream_go_in) begin
            state    <= STREAM;
            accept_q <= 1'b1;
            index_q  <= rd_row;
            weight_q <= wbuf[rd_row];
            cnt      <= cnt + CW'(1);
          end
        end
        STREAM: begin
          if (cnt != CNT_FULL) begin
            accept_q <= 1'b1;
            index_q  <= rd_row;
            weight_q <= wbuf[rd_row];
            cnt      <= cnt + CW'(1);
          end else begin
            state           <= DONE;
            tile_loaded_out <= 1'b1;
          end
        end
        DONE: begin
          state        <= FILL;
          cnt          <= '0;
          load_ready_q <= 1'b1;
          busy_out     <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_column_loader.sv
// tb/tb_weight_column_loader.sv - directed self-checking bench for the weight column loader with a PE column model
module tb_weight_column_loader;
  import weight_column_loader_pkg::*;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stream_go = 1'b0;
  logic err_clr = 1'b0;
  logic busy, loaded, terr;
  logic pe_switch = 1'b0;
  int   checks = 0;
  int   errors = 0;

  weight_column_loader_if #(.DATA_WIDTH_IN(DW), .INDEX_WIDTH(IW)) bus();

  weight_column_loader #(.SYSTOLIC_ARRAY_WIDTH(N), .DATA_WIDTH_IN(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stream_go_in(stream_go), .err_clr_in(err_clr),
    .busy_out(busy), .tile_loaded_out(loaded), .tile_err_out(terr)
  );

  always #5 clk = ~clk;

  // Column of N PEs: each forwards accept/index/weight one row down per cycle
  logic          pa [N];
  logic [IW-1:0] pi [N];
  logic [DW-1:0] pw [N];
  logic [DW-1:0] inact [N];
  logic [DW-1:0] act [N];

  always @(posedge clk) begin
    logic          a;
    logic [IW-1:0] i;
    logic [DW-1:0] w;
    for (int r = 0; r < N; r++) begin
      if (r == 0) begin
        a = bus.col_accept_w_out; i = bus.col_index_out; w = bus.col_weight_out;
      end else begin
        a = pa[r-1]; i = pi[r-1]; w = pw[r-1];
      end
      pa[r] <= a;
      pi[r] <= i;
      pw[r] <= w;
      if (a && i == IW'(r)) inact[r] <= w;
      if (pe_switch) act[r] <= inact[r];
    end
  end

  function automatic logic [DW-1:0] ew(input int base, input int r);
    return DW'(base + r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_col_zero(input string tag);
    check({tag, "_accept"}, 32'(bus.col_accept_w_out), 32'(0));
    check({tag, "_index"}, 32'(bus.col_index_out), 32'(0));
    check({tag, "_weight"}, 32'($unsigned(bus.col_weight_out)), 32'(0));
  endtask

  task automatic load_tile(input int base, input int last_pos, input bit hold_valid);
    for (int r = 0; r < N; r++) begin
      bus.load_valid_in  = 1'b1;
      bus.load_weight_in = ew(base, r);
      bus.load_last_in   = (r == last_pos);
      tick();
      if (r == N - 2) check("ready_before_full", 32'(bus.load_ready_out), 32'(1));
    end
    bus.load_valid_in  = hold_valid;
    bus.load_weight_in = 8'sh77;
    bus.load_last_in   = 1'b0;
    check("ready_after_full", 32'(bus.load_ready_out), 32'(0));
    check("busy_after_full", 32'(busy), 32'(1));
  endtask

  task automatic stream_tile(input int base, input int stop_k);
    stream_go = 1'b1;
    tick();
    stream_go = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("stream_accept", 32'(bus.col_accept_w_out), 32'(1));
      check("stream_index", 32'(bus.col_index_out), 32'(N - 1 - k));
      check("stream_weight", 32'($unsigned(bus.col_weight_out)), 32'(ew(base, N - 1 - k)));
      if (k == stop_k) return;
      if (k < N - 1) tick();
    end
    tick();
    check("done_loaded", 32'(loaded), 32'(1));
    check("done_busy", 32'(busy), 32'(1));
    check_col_zero("done");
    for (int r = 0; r < N; r++) check("pe_inactive", 32'(inact[r]), 32'(ew(base, r)));
    tick();
    check("fill_loaded", 32'(loaded), 32'(0));
    check("fill_busy", 32'(busy), 32'(0));
    check("fill_ready", 32'(bus.load_ready_out), 32'(1));
  endtask

  initial begin
    int bad;
    bus.load_valid_in  = 1'b0;
    bus.load_weight_in = '0;
    bus.load_last_in   = 1'b0;

    // Reset held, then released
    repeat (3) tick();
    check("rst_ready", 32'(bus.load_ready_out), 32'(0));
    check_col_zero("rst");
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_loaded", 32'(loaded), 32'(0));
    check("rst_err", 32'(terr), 32'(0));
    rst = 1'b1;
    #1;
    check("release_ready_before_clk", 32'(bus.load_ready_out), 32'(0));
    tick();
    check("release_ready", 32'(bus.load_ready_out), 32'(1));
    check("release_busy", 32'(busy), 32'(0));

    // Basic tile plus a long wait for go
    load_tile(10, N - 1, 1'b0);
    check("tile1_err", 32'(terr), 32'(0));
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.load_ready_out || bus.col_accept_w_out || !busy) bad++;
    end
    check("hold_ready_state", 32'(bad), 32'(0));
    stream_tile(10, N);
    pe_switch = 1'b1;
    tick();
    pe_switch = 1'b0;
    for (int r = 0; r < N; r++) check("pe_active", 32'(act[r]), 32'(ew(10, r)));

    // Valid held high outside FILL, negative weights
    load_tile(-60, N - 1, 1'b1);
    repeat (3) tick();
    check("ready_held_low", 32'(bus.load_ready_out), 32'(0));
    stream_tile(-60, N);
    bus.load_valid_in = 1'b0;

    // Misplaced last flag
    load_tile(100, 5, 1'b0);
    check("err_set", 32'(terr), 32'(1));
    stream_tile(100, N);
    check("err_sticky", 32'(terr), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(terr), 32'(0));

    // Reset in the middle of a stream
    load_tile(30, N - 1, 1'b0);
    stream_tile(30, 7);
    #1 rst = 1'b0;
    #1;
    check_col_zero("midrst");
    check("midrst_ready", 32'(bus.load_ready_out), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.load_ready_out), 32'(1));
    check("post_rst_busy", 32'(busy), 32'(0));
    load_tile(-5, N - 1, 1'b0);
    stream_tile(-5, N);
    check("final_err", 32'(terr), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
